// File: rtl/task_in_frame_sched.sv
//------------------------------------------------------------------------------
// Module   : task_in_frame_sched
// Brief    : Frame-granular scheduler in front of the task input buffer.
//            Picks one of NUM_SRC stream sources round-robin and forwards one
//            whole frame into the buffer. Frames longer than NUM_WORDS are
//            cut at NUM_WORDS and the tail is discarded. Shorter frames are
//            flagged. The block then paces consumer read requests and pulses
//            o_output_last once every loaded word has been read.
// Options  : `define TASK_SCHED_PRIO_EN gives source 0 strict priority.
//            Round-robin then covers sources 1..NUM_SRC-1 only.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module task_in_frame_sched #(
  parameter  int NUM_SRC    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_WORDS  = 243,
  localparam int SRC_W      = $clog2(NUM_SRC),
  localparam int CNT_W      = $clog2(NUM_WORDS + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_SRC-1:0]            i_src_tvalid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] i_src_tdata,
  input  logic [NUM_SRC-1:0]            i_src_tlast,
  output logic [NUM_SRC-1:0]            o_src_tready,
  output logic                          o_buf_tvalid,
  output logic [DATA_WIDTH-1:0]         o_buf_tdata,
  output logic                          o_buf_tlast,
  input  logic                          i_buf_tready,
  input  logic                          i_cons_ready,
  output logic                          o_data_req,
  input  logic                          i_buf_rd,
  output logic                          o_output_last,
  output logic [SRC_W-1:0]              o_src_id,
  output logic                          o_frame_err,
  output logic                          o_busy
);

  localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(NUM_SRC - 1);
  localparam logic [SRC_W:0]   NSRC_EXT  = (SRC_W + 1)'(NUM_SRC);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_LOAD  = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t             state_q;
  logic [SRC_W-1:0]   grant_q;
  logic [SRC_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]   ld_cnt_q;
  logic [CNT_W-1:0]   rd_cnt_q;
  logic               output_last_q;
  logic               frame_err_q;

  logic [NUM_SRC-1:0]    grant_oh;
  logic                  sel_tvalid;
  logic                  sel_tlast;
  logic [DATA_WIDTH-1:0] sel_tdata;
  logic [SRC_W-1:0]      grant_next;
  logic [SRC_W:0]        cand;
  logic [SRC_W-1:0]      arb_idx;
  logic                  arb_found;
  logic                  beat;
  logic                  rd_final;

  // Route the granted source's stream onto a single set of select signals
  always_comb begin
    grant_oh   = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_tdata  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant_q == SRC_W'(k)) begin
        grant_oh[k] = 1'b1;
        sel_tvalid  = i_src_tvalid[k];
        sel_tlast   = i_src_tlast[k];
        sel_tdata   = i_src_tdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pick the first requesting source at or after rr_ptr, wrapping around.
  // In priority builds source 0 pre-empts the search whenever it is valid.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
`ifdef TASK_SCHED_PRIO_EN
    if (i_src_tvalid[0]) begin
      arb_found = 1'b1;
    end
`else
`endif
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = {1'b0, rr_ptr_q} + (SRC_W + 1)'(i);
      if (cand >= NSRC_EXT) begin
        cand = cand - NSRC_EXT;
      end
      if (!arb_found && i_src_tvalid[cand[SRC_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[SRC_W-1:0];
      end
    end
  end

  assign grant_next = (grant_q == LAST_SRC) ? '0 : grant_q + 1'b1;
  assign beat       = (state_q == S_LOAD) && sel_tvalid && i_buf_tready;
  // rd_cnt < ld_cnt <= NUM_WORDS in S_DRAIN, so the +1 cannot overflow
  assign rd_final   = (rd_cnt_q + 1'b1) == ld_cnt_q;

  // Stream-side outputs: pass-through while loading, swallow beats while flushing
  always_comb begin
    o_buf_tvalid = 1'b0;
    o_buf_tdata  = '0;
    o_buf_tlast  = 1'b0;
    o_src_tready = '0;
    if (state_q == S_LOAD) begin
      o_buf_tvalid = sel_tvalid;
      o_buf_tdata  = sel_tdata;
      // Beat NUM_WORDS always closes the buffered frame, even if the source runs on
      o_buf_tlast  = sel_tlast || (ld_cnt_q == LAST_WORD);
      o_src_tready = grant_oh & {NUM_SRC{i_buf_tready}};
    end else if (state_q == S_FLUSH) begin
      o_src_tready = grant_oh;
    end
  end

  // Frame sequencer: arbitrate, load, optionally flush the tail, then drain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      ld_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      output_last_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      output_last_q <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|i_src_tvalid) begin
            state_q <= S_ARB;
          end
        end
        S_ARB: begin
          // A source that withdrew its request leaves nothing to grant
          if (arb_found) begin
            grant_q  <= arb_idx;
            ld_cnt_q <= '0;
            rd_cnt_q <= '0;
            state_q  <= S_LOAD;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (beat) begin
            ld_cnt_q <= ld_cnt_q + 1'b1;
            if (sel_tlast) begin
              frame_err_q <= (ld_cnt_q != LAST_WORD);
              state_q     <= S_DRAIN;
            end else if (ld_cnt_q == LAST_WORD) begin
              frame_err_q <= 1'b1;
              state_q     <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (sel_tvalid && sel_tlast) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (i_buf_rd) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
            if (rd_final) begin
              output_last_q <= 1'b1;
              state_q       <= S_IDLE;
`ifdef TASK_SCHED_PRIO_EN
              // Source 0 frames do not disturb the rotation among the others
              if (grant_q != '0) begin
                rr_ptr_q <= grant_next;
              end
`else
              rr_ptr_q <= grant_next;
`endif
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_data_req    = (state_q == S_DRAIN) && i_cons_ready;
  assign o_output_last = output_last_q;
  assign o_frame_err   = frame_err_q;
  assign o_src_id      = grant_q;
  assign o_busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_task_in_frame_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_task_in_frame_sched
// Brief    : Self-checking bench for task_in_frame_sched (NUM_WORDS=8).
//            Directed frames are followed by randomized rounds. A frame-level
//            reference model predicts every output on every cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_task_in_frame_sched;

  localparam int NS = 4;
  localparam int DW = 8;
  localparam int NW = 8;
  localparam int SW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NS-1:0]    src_tvalid;
  logic [NS*DW-1:0] src_tdata;
  logic [NS-1:0]    src_tlast;
  logic [NS-1:0]    src_tready;
  logic             buf_tvalid;
  logic [DW-1:0]    buf_tdata;
  logic             buf_tlast;
  logic             buf_tready;
  logic             cons_ready;
  logic             data_req;
  logic             buf_rd;
  logic             output_last;
  logic [SW-1:0]    src_id;
  logic             frame_err;
  logic             busy;

  always #5 clk = ~clk;

  task_in_frame_sched #(.NUM_SRC(NS), .DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_src_tvalid(src_tvalid), .i_src_tdata(src_tdata), .i_src_tlast(src_tlast),
    .o_src_tready(src_tready),
    .o_buf_tvalid(buf_tvalid), .o_buf_tdata(buf_tdata), .o_buf_tlast(buf_tlast),
    .i_buf_tready(buf_tready), .i_cons_ready(cons_ready), .o_data_req(data_req),
    .i_buf_rd(buf_rd), .o_output_last(output_last), .o_src_id(src_id),
    .o_frame_err(frame_err), .o_busy(busy)
  );

  typedef struct {logic [DW-1:0] d; logic l;} beat_t;
  typedef enum {M_IDLE, M_ARB, M_LOAD, M_FLUSH, M_DRAIN} mph_t;

  // Pending beats per source; the driver presents the head, the model pops it
  beat_t src_q [NS][$];
  int    f_len   [NS];
  int    f_words [NS];
  bit    f_err   [NS];

  // Frame-level reference model
  mph_t m_ph;
  int   m_grant, m_rr, m_src_id, m_fwd, m_rd, m_words;
  bit   m_last_p, m_err_p;

  // Observations used by the hand-computed directed expectations
  int obs_fwd, obs_last, obs_err, obs_tl;
  int obs_ids[$];

  int checks = 0;
  int errors = 0;
  int tr_mode, rd_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NS-1:0] v, input int rr);
`ifdef TASK_SCHED_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int i = 0; i < NS; i++) if (v[(rr + i) % NS]) return (rr + i) % NS;
    return 0;
  endfunction

  function automatic bit queues_empty();
    for (int k = 0; k < NS; k++) if (src_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_ph = M_IDLE; m_grant = 0; m_rr = 0; m_src_id = 0;
    m_fwd = 0; m_rd = 0; m_words = 0; m_last_p = 0; m_err_p = 0;
  endtask

  task automatic clear_obs();
    obs_fwd = 0; obs_last = 0; obs_err = 0; obs_tl = 0;
    obs_ids.delete();
  endtask

  task automatic push_frame(input int k, input int len);
    beat_t t;
    for (int b = 1; b <= len; b++) begin
      t.d = DW'($urandom);
      t.l = (b == len);
      src_q[k].push_back(t);
    end
    f_len[k]   = len;
    f_words[k] = (len < NW) ? len : NW;
    f_err[k]   = (len != NW);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tready"},  src_tready,  0);
    chk({tag, "_tvalid"},  buf_tvalid,  0);
    chk({tag, "_tdata"},   buf_tdata,   0);
    chk({tag, "_tlast"},   buf_tlast,   0);
    chk({tag, "_datareq"}, data_req,    0);
    chk({tag, "_olast"},   output_last, 0);
    chk({tag, "_srcid"},   src_id,      0);
    chk({tag, "_err"},     frame_err,   0);
    chk({tag, "_busy"},    busy,        0);
  endtask

  // Compare this cycle's outputs with the model, then advance the model
  // across the upcoming clock edge
  task automatic check_and_step();
    logic [NS-1:0] exp_rdy;
    logic          exp_tv;
    beat_t         h;
    chk("busy",        busy,        m_ph != M_IDLE);
    chk("src_id",      src_id,      m_src_id);
    chk("output_last", output_last, m_last_p);
    chk("frame_err",   frame_err,   m_err_p);
    exp_rdy = '0;
    exp_tv  = 1'b0;
    if (m_ph == M_LOAD) begin
      exp_tv = src_tvalid[m_grant];
      exp_rdy[m_grant] = buf_tready;
    end else if (m_ph == M_FLUSH) begin
      exp_rdy[m_grant] = 1'b1;
    end
    chk("src_tready", src_tready, exp_rdy);
    chk("buf_tvalid", buf_tvalid, exp_tv);
    if (exp_tv) begin
      chk("buf_tdata", buf_tdata, src_q[m_grant][0].d);
      chk("buf_tlast", buf_tlast, (m_fwd + 1) == m_words);
    end
    chk("data_req", data_req, (m_ph == M_DRAIN) && cons_ready);

    if (buf_tvalid && buf_tready) begin
      obs_fwd++;
      if (buf_tlast) obs_tl++;
    end
    if (output_last) begin
      obs_last++;
      obs_ids.push_back(int'(src_id));
    end
    if (frame_err) obs_err++;

    m_last_p = 1'b0;
    m_err_p  = 1'b0;
    case (m_ph)
      M_IDLE: if (|src_tvalid) m_ph = M_ARB;
      M_ARB: begin
        m_grant  = pick(src_tvalid, m_rr);
        m_src_id = m_grant;
        m_fwd    = 0;
        m_rd     = 0;
        m_words  = f_words[m_grant];
        m_ph     = M_LOAD;
      end
      M_LOAD: if (src_tvalid[m_grant] && buf_tready) begin
        h = src_q[m_grant].pop_front();
        m_fwd++;
        if (m_fwd == m_words) begin
          m_err_p = f_err[m_grant];
          m_ph    = (f_len[m_grant] > NW) ? M_FLUSH : M_DRAIN;
        end
      end
      M_FLUSH: if (src_tvalid[m_grant]) begin
        h = src_q[m_grant].pop_front();
        if (src_q[m_grant].size() == 0) m_ph = M_DRAIN;
      end
      M_DRAIN: if (buf_rd) begin
        m_rd++;
        if (m_rd == m_words) begin
          m_last_p = 1'b1;
          m_ph     = M_IDLE;
`ifdef TASK_SCHED_PRIO_EN
          if (m_grant != 0) m_rr = (m_grant + 1) % NS;
`else
          m_rr = (m_grant + 1) % NS;
`endif
        end
      end
      default: m_ph = M_IDLE;
    endcase
  endtask

  // One clock: drive on the falling edge, sample 1 ns later
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < NS; k++) begin
      if (src_q[k].size() > 0) begin
        src_tvalid[k] = 1'b1;
        src_tdata[k*DW +: DW] = src_q[k][0].d;
        src_tlast[k] = src_q[k][0].l;
      end else begin
        src_tvalid[k] = 1'b0;
        src_tdata[k*DW +: DW] = '0;
        src_tlast[k] = 1'b0;
      end
    end
    case (tr_mode)
      0:       buf_tready = 1'b1;
      1:       buf_tready = ~buf_tready;
      default: buf_tready = 1'($urandom_range(0, 1));
    endcase
    if (rd_mode == 0) begin
      buf_rd = 1'b1; cons_ready = 1'b1;
    end else begin
      buf_rd = 1'($urandom_range(0, 1)); cons_ready = 1'($urandom_range(0, 1));
    end
    #1;
    check_and_step();
  endtask

  task automatic run_idle(input string name, input int budget);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!(m_ph == M_IDLE && !m_last_p && queues_empty()) && n < budget);
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d cycles required under %0d", name, n, budget);
    end
  endtask

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: got timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst_n = 1'b0; src_tvalid = '1; src_tdata = '1; src_tlast = '0;
    buf_tready = 1'b1; cons_ready = 1'b1; buf_rd = 1'b0;
    tr_mode = 0; rd_mode = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    src_tvalid = '0; src_tdata = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // src0 and src2 together from rr_ptr=0: src0 first, then src2
    clear_obs();
    push_frame(0, NW); push_frame(2, NW);
    run_idle("t2", 200);
    chk("t2_frames", obs_ids.size(), 2);
    if (obs_ids.size() == 2) begin
      chk("t2_first",  obs_ids[0], 0);
      chk("t2_second", obs_ids[1], 2);
    end
    chk("t2_fwd", obs_fwd, 2 * NW);

    // Nominal frame from src1, one strobe per cycle
    clear_obs();
    push_frame(1, NW);
    run_idle("t1", 100);
    chk("t1_fwd", obs_fwd, 8);
    chk("t1_last", obs_last, 1);
    chk("t1_err", obs_err, 0);
    chk("t1_id", (obs_ids.size() > 0) ? obs_ids[0] : -1, 1);
    chk("t1_rr", m_rr, 2);

    // Short frame from src3
    clear_obs();
    push_frame(3, 5);
    run_idle("t3", 100);
    chk("t3_fwd", obs_fwd, 5);
    chk("t3_err", obs_err, 1);
    chk("t3_last", obs_last, 1);

    // Long frame from src2: truncated to 8, tail flushed
    clear_obs();
    push_frame(2, 11);
    run_idle("t4", 100);
    chk("t4_fwd", obs_fwd, 8);
    chk("t4_tlast", obs_tl, 1);
    chk("t4_err", obs_err, 1);
    chk("t4_last", obs_last, 1);

    // Buffer ready toggling every cycle during the load
    clear_obs();
    tr_mode = 1;
    push_frame(2, NW);
    run_idle("t5", 200);
    chk("t5_fwd", obs_fwd, 8);
    chk("t5_err", obs_err, 0);
    tr_mode = 0;

    // Reset after 4 beats of a src1 frame, then src1+src3 must restart from rr_ptr=0
    clear_obs();
    push_frame(1, NW);
    begin
      int n = 0;
      while (obs_fwd < 4 && n < 50) begin cycle(); n++; end
      chk("t6_reach4", obs_fwd, 4);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    for (int k = 0; k < NS; k++) src_q[k].delete();
    src_tvalid = '0; src_tdata = '0; src_tlast = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    push_frame(1, NW); push_frame(3, NW);
    run_idle("t6", 200);
    chk("t6_frames", obs_ids.size(), 2);
    if (obs_ids.size() == 2) begin
      chk("t6_first",  obs_ids[0], 1);
      chk("t6_second", obs_ids[1], 3);
    end
    chk("t6_err", obs_err, 0);

    // Randomized rounds: random source sets, lengths, ready and read patterns
    for (int r = 0; r < 60; r++) begin
      int mask;
      mask    = $urandom_range(1, (1 << NS) - 1);
      tr_mode = $urandom_range(0, 2);
      rd_mode = $urandom_range(0, 1);
      for (int k = 0; k < NS; k++) begin
        if (mask[k]) begin
          if ($urandom_range(0, 2) == 0) push_frame(k, NW);
          else push_frame(k, $urandom_range(1, NW + 4));
        end
      end
      run_idle("rand", 3000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
